exe_alu_stage: RTL and testbench



---
 rtl/arm_exe_pkg.sv | 44 ++++
 rtl/arm_alu.sv | 56 +++++
 rtl/exe_alu_stage.sv | 91 +++++++++
 tb/tb_exe_alu_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_exe_pkg.sv
// Shared definitions for the ARM execute stage: ALU command codes, NZCV bit
// positions, the registered control bundle and small command-class helpers.
package arm_exe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctl_t;

  // Codes outside this set produce 0 and never touch the status register.
  function automatic logic cmd_known(input logic [3:0] cmd);
    case (cmd)
      EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
      EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Only the adder-based commands produce C and V.
  function automatic logic cmd_arith(input logic [3:0] cmd);
    case (cmd)
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational ALU: result and candidate NZCV for one execute command.
// C/V are only meaningful for arithmetic commands; the caller merges them.
module arm_alu
  import arm_exe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    exe_cmd,
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic          c_in,
  output logic [DW-1:0] res,
  output logic [3:0]    nzcv_next
);

  logic [DW:0] sum;
  logic        is_sub;
  logic        arith;

  always_comb begin
    sum    = '0;
    res    = '0;
    is_sub = 1'b0;
    arith  = cmd_arith(exe_cmd);
    // Subtracts go through the same 33-bit adder so bit 32 is NOT-borrow.
    case (exe_cmd)
      EXE_MOV: res = val2;
      EXE_MVN: res = ~val2;
      EXE_ADD: sum = {1'b0, val1} + {1'b0, val2};
      EXE_ADC: sum = {1'b0, val1} + {1'b0, val2} + {{DW{1'b0}}, c_in};
      EXE_SUB: begin
        sum    = {1'b0, val1} + {1'b0, ~val2} + {{DW{1'b0}}, 1'b1};
        is_sub = 1'b1;
      end
      EXE_SBC: begin
        sum    = {1'b0, val1} + {1'b0, ~val2} + {{DW{1'b0}}, c_in};
        is_sub = 1'b1;
      end
      EXE_AND: res = val1 & val2;
      EXE_ORR: res = val1 | val2;
      EXE_EOR: res = val1 ^ val2;
      default: res = '0;
    endcase
    if (arith) res = sum[DW-1:0];

    nzcv_next       = '0;
    nzcv_next[ST_N] = res[DW-1];
    nzcv_next[ST_Z] = ~|res;
    nzcv_next[ST_C] = arith ? sum[DW] : c_in;
    // Overflow: operand signs agree (add) or differ (sub), and result sign flips.
    nzcv_next[ST_V] = arith
                    & ((val1[DW-1] ^ val2[DW-1]) == is_sub)
                    & (res[DW-1] != val1[DW-1]);
  end

endmodule

// File: rtl/exe_alu_stage.sv
// Execute-stage ALU, NZCV status register and EX/MEM pipeline register.
// Optional STATUS_BYPASS_EN adds status_fwd, the NZCV value about to be written.
module exe_alu_stage
  import arm_exe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        exe_cmd,
  input  logic              s_in,
  input  logic [DW-1:0]     val1,
  input  logic [DW-1:0]     val2,
  input  logic [DW-1:0]     st_val_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [REG_AW-1:0] dest_in,
`ifdef STATUS_BYPASS_EN
  output logic [3:0]        status_fwd,
`endif
  output logic [3:0]        status,
  output logic [DW-1:0]     alu_res,
  output logic [DW-1:0]     st_val,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [REG_AW-1:0] dest,
  output logic              valid_out
);

  logic [DW-1:0] res;
  logic [3:0]    nzcv_next;
  logic [3:0]    status_new;
  logic          status_we;
  ctl_t          ctl_q;

  arm_alu #(.DW(DW)) u_alu (
    .exe_cmd   (exe_cmd),
    .val1      (val1),
    .val2      (val2),
    .c_in      (status[ST_C]),
    .res       (res),
    .nzcv_next (nzcv_next)
  );

  // Logical and move commands keep the previous C and V.
  assign status_new = cmd_arith(exe_cmd) ? nzcv_next
                                         : {nzcv_next[ST_N], nzcv_next[ST_Z],
                                            status[ST_C], status[ST_V]};
  assign status_we  = valid_in & s_in & ~freeze & ~flush & cmd_known(exe_cmd);

`ifdef STATUS_BYPASS_EN
  assign status_fwd = status_we ? status_new : status;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         status <= '0;
    else if (status_we) status <= status_new;
  end

  // Flush only needs to kill control; data left stale is never consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q   <= '0;
      alu_res <= '0;
      st_val  <= '0;
      dest    <= '0;
    end else if (flush) begin
      ctl_q   <= '0;
    end else if (!freeze) begin
      ctl_q.valid    <= valid_in;
      ctl_q.wb_en    <= valid_in & wb_en_in;
      ctl_q.mem_r_en <= valid_in & mem_r_en_in;
      ctl_q.mem_w_en <= valid_in & mem_w_en_in;
      alu_res        <= res;
      st_val         <= st_val_in;
      dest           <= dest_in;
    end
  end

  assign valid_out = ctl_q.valid;
  assign wb_en     = ctl_q.wb_en;
  assign mem_r_en  = ctl_q.mem_r_en;
  assign mem_w_en  = ctl_q.mem_w_en;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Self-checking bench for exe_alu_stage: directed steps then random traffic
// against a signed/unsigned-arithmetic reference model of the execute stage.
module tb_exe_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, valid_in, s_in;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, st_val_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [3:0]  dest_in;
  logic [3:0]  status;
  logic [31:0] alu_res, st_val;
  logic        wb_en, mem_r_en, mem_w_en, valid_out;
  logic [3:0]  dest;
`ifdef STATUS_BYPASS_EN
  logic [3:0]  status_fwd;
`endif

  exe_alu_stage #(.DW(32), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .valid_in(valid_in), .exe_cmd(exe_cmd), .s_in(s_in),
    .val1(val1), .val2(val2), .st_val_in(st_val_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .dest_in(dest_in),
`ifdef STATUS_BYPASS_EN
    .status_fwd(status_fwd),
`endif
    .status(status), .alu_res(alu_res), .st_val(st_val),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .dest(dest), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (what the stage outputs should show)
  logic [3:0]  m_status;
  logic        m_valid, m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the arithmetic definition: 64-bit unsigned
  // sums give the carry/not-borrow, 64-bit signed sums give overflow.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, b,
                                  input logic [3:0] st, output logic [31:0] r,
                                  output logic [3:0] ns, output bit upd);
    longint ua, ub, sa, sb, u, s, cin, brw;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = longint'(st[1]);
    ns = st; upd = 1'b1; r = '0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        u = ua + ub + ((cmd == 4'd3) ? cin : 0);
        s = sa + sb + ((cmd == 4'd3) ? cin : 0);
        r = u[31:0];
        ns[1] = (u >= (longint'(1) <<< 32));
        ns[0] = (s > longint'(32'h7fffffff)) || (s < -(longint'(1) <<< 31));
      end
      4'd4, 4'd5: begin
        brw = (cmd == 4'd4) ? 0 : 1 - cin;
        u = ua - ub - brw;
        s = sa - sb - brw;
        r = u[31:0];
        ns[1] = (u >= 0);
        ns[0] = (s > longint'(32'h7fffffff)) || (s < -(longint'(1) <<< 31));
      end
      default: begin r = '0; upd = 1'b0; end
    endcase
    if (upd) begin
      ns[3] = r[31];
      ns[2] = (r == 32'd0);
    end
  endfunction

  function automatic logic [3:0] pending_status();
    logic [31:0] r; logic [3:0] ns; bit upd;
    ref_alu(exe_cmd, val1, val2, m_status, r, ns, upd);
    return (valid_in && s_in && !freeze && !flush && upd) ? ns : m_status;
  endfunction

  task automatic model_reset();
    m_status = '0; m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_res = '0; m_st = '0; m_dest = '0;
  endtask

  task automatic model_edge();
    logic [31:0] r; logic [3:0] ns; bit upd;
    ref_alu(exe_cmd, val1, val2, m_status, r, ns, upd);
    if (flush) begin
      m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    end else if (!freeze) begin
      if (valid_in && s_in && upd) m_status = ns;
      m_valid = valid_in;
      m_wb = valid_in & wb_en_in; m_mr = valid_in & mem_r_en_in; m_mw = valid_in & mem_w_en_in;
      m_res = r; m_st = st_val_in; m_dest = dest_in;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".status"}, {28'd0, status}, {28'd0, m_status});
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
    check({tag, ".ctl"}, {29'd0, wb_en, mem_r_en, mem_w_en}, {29'd0, m_wb, m_mr, m_mw});
    if (m_valid) begin
      check({tag, ".res"}, alu_res, m_res);
      check({tag, ".st_val"}, st_val, m_st);
      check({tag, ".dest"}, {28'd0, dest}, {28'd0, m_dest});
    end
  endtask

  // One clock: inputs already set; optional forward check mid-cycle, then edge.
  task automatic step(input string tag);
    @(negedge clk);
`ifdef STATUS_BYPASS_EN
    check({tag, ".fwd"}, {28'd0, status_fwd}, {28'd0, pending_status()});
`endif
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic s, input logic [31:0] a, b);
    valid_in = 1; freeze = 0; flush = 0;
    exe_cmd = cmd; s_in = s; val1 = a; val2 = b;
    st_val_in = $urandom; dest_in = 4'($urandom);
    wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; freeze = 0; flush = 0; valid_in = 0; s_in = 0; exe_cmd = '0;
    val1 = '0; val2 = '0; st_val_in = '0; wb_en_in = 0; mem_r_en_in = 0;
    mem_w_en_in = 0; dest_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.status", {28'd0, status}, 32'd0);
    check("reset.res", alu_res, 32'd0);
    check("reset.ctl", {27'd0, valid_out, wb_en, mem_r_en, mem_w_en, 1'b0}, 32'd0);
    @(negedge clk); rst_n = 1;

    // 1: signed overflow on ADD
    drive(4'b0010, 1, 32'h7FFF_FFFF, 32'h0000_0001); step("t1");
    check("t1.res_c", alu_res, 32'h8000_0000);
    check("t1.nzcv_c", {28'd0, status}, 32'b1001);

    // 2: SUB equal operands, then borrow
    drive(4'b0100, 1, 32'd5, 32'd5); step("t2a");
    check("t2a.res_c", alu_res, 32'd0);
    check("t2a.nzcv_c", {28'd0, status}, 32'b0110);
    drive(4'b0100, 1, 32'd0, 32'd1); step("t2b");
    check("t2b.res_c", alu_res, 32'hFFFF_FFFF);
    check("t2b.nzcv_c", {28'd0, status}, 32'b1000);

    // 3: carry in for ADC / SBC
    drive(4'b0010, 1, 32'hFFFF_FFFF, 32'd1); step("t3a");
    check("t3a.nzcv_c", {28'd0, status}, 32'b0110);
    drive(4'b0011, 0, 32'd1, 32'd2); step("t3b");
    check("t3b.res_c", alu_res, 32'd4);
    check("t3b.nzcv_c", {28'd0, status}, 32'b0110);
    drive(4'b0101, 0, 32'd10, 32'd3); step("t3c");
    check("t3c.res_c", alu_res, 32'd7);

    // 4: freeze holds everything while inputs wander
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1, $urandom, $urandom);
      freeze = 1; step("t4.frz");
      check("t4.res_hold", alu_res, 32'd7);
      check("t4.st_hold", {28'd0, status}, 32'b0110);
    end
    drive(4'b0001, 0, 32'd0, 32'hCAFE_F00D); step("t4.rel");
    check("t4.rel_c", alu_res, 32'hCAFE_F00D);

    // 5: flush beats freeze
    drive(4'b0010, 1, 32'd1, 32'd1); flush = 1; freeze = 1; step("t5");
    check("t5.valid_c", {30'd0, valid_out, wb_en}, 32'd0);
    check("t5.nzcv_c", {28'd0, status}, 32'b0110);

    // 6: asynchronous reset between edges
    drive(4'b0010, 1, 32'd3, 32'd4); step("t6a");
    #2 rst_n = 0;
    #1 model_reset();
    check("t6.rst_res", alu_res, 32'd0);
    check("t6.rst_st", {28'd0, status}, 32'd0);
    check("t6.rst_ctl", {28'd0, valid_out, wb_en, mem_r_en, mem_w_en}, 32'd0);
    @(negedge clk); rst_n = 1;
    drive(4'b0001, 0, 32'd0, 32'h1234_5678); step("t6b");
    check("t6b.res_c", alu_res, 32'h1234_5678);

    // Random traffic, including unknown commands and mixed freeze/flush
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 1'($urandom), rand_val(), rand_val());
      valid_in = ($urandom_range(0, 9) < 8);
      freeze = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
      wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
